// File: rtl/poker_pkg.sv
// Shared card/hand definitions for the showdown round sequencer and its classifier.
package poker_pkg;

  localparam int unsigned SUIT_W    = 2;
  localparam int unsigned RANK_W    = 4;
  localparam int unsigned CARD_W    = 6;
  localparam int unsigned HAND_SIZE = 5;

  typedef logic [3:0] hand_type_t;

  localparam hand_type_t HIGH_CARD      = 4'd0;
  localparam hand_type_t ONE_PAIR       = 4'd1;
  localparam hand_type_t TWO_PAIR       = 4'd2;
  localparam hand_type_t THREE_KIND     = 4'd3;
  localparam hand_type_t STRAIGHT       = 4'd4;
  localparam hand_type_t FLUSH          = 4'd5;
  localparam hand_type_t FULL_HOUSE     = 4'd6;
  localparam hand_type_t FOUR_KIND      = 4'd7;
  localparam hand_type_t STRAIGHT_FLUSH = 4'd8;

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;

endpackage

// File: rtl/poker_round_ctrl_if.sv
// Card stream and result handshake bundle between the dealer front end and the round sequencer.
interface poker_round_ctrl_if #(
  parameter int unsigned NUM_PLAYERS = 4
) ();
  import poker_pkg::*;

  localparam int unsigned PW = $clog2(NUM_PLAYERS);

  logic              start;
  logic              card_valid;
  logic              card_ready;
  logic [CARD_W-1:0] card_data;
  logic              busy;
  logic              res_valid;
  logic              res_ready;
  logic [PW-1:0]     res_winner;
  logic [3:0]        res_type;
  logic              res_tie;

  modport master (
    output start, card_valid, card_data, res_ready,
    input  card_ready, busy, res_valid, res_winner, res_type, res_tie
  );

  modport slave (
    input  start, card_valid, card_data, res_ready,
    output card_ready, busy, res_valid, res_winner, res_type, res_tie
  );

endinterface

// File: rtl/poker.sv
// Combinational 5-card hand classifier; ranks 2..14 with ace-low straight support.
module poker
  import poker_pkg::*;
(
  input  logic [HAND_SIZE-1:0][CARD_W-1:0] cards,
  output logic [3:0]                       hand_type
);

  logic [3:0]        pairs;
  logic [15:0]       present;
  logic [RANK_W-1:0] max_r;
  logic [RANK_W-1:0] min_r;
  logic              flush;
  logic              wheel;
  logic              straight;

  // Equal-rank pair count over all 10 card pairs uniquely identifies the rank pattern.
  always_comb begin
    pairs   = '0;
    present = '0;
    max_r   = '0;
    min_r   = '1;
    flush   = 1'b1;
    for (int unsigned i = 0; i < HAND_SIZE; i++) begin
      present[cards[i][RANK_W-1:0]] = 1'b1;
      if (cards[i][RANK_W-1:0] > max_r) max_r = cards[i][RANK_W-1:0];
      if (cards[i][RANK_W-1:0] < min_r) min_r = cards[i][RANK_W-1:0];
      if (cards[i][CARD_W-1:RANK_W] != cards[0][CARD_W-1:RANK_W]) flush = 1'b0;
      for (int unsigned j = i + 1; j < HAND_SIZE; j++) begin
        if (cards[i][RANK_W-1:0] == cards[j][RANK_W-1:0]) pairs = pairs + 4'd1;
      end
    end
    wheel    = present[14] & present[2] & present[3] & present[4] & present[5];
    straight = (pairs == 4'd0) && (((max_r - min_r) == RANK_W'(4)) || wheel);

    if (straight && flush)   hand_type = STRAIGHT_FLUSH;
    else if (pairs == 4'd6)  hand_type = FOUR_KIND;
    else if (pairs == 4'd4)  hand_type = FULL_HOUSE;
    else if (flush)          hand_type = FLUSH;
    else if (straight)       hand_type = STRAIGHT;
    else if (pairs == 4'd3)  hand_type = THREE_KIND;
    else if (pairs == 4'd2)  hand_type = TWO_PAIR;
    else if (pairs == 4'd1)  hand_type = ONE_PAIR;
    else                     hand_type = HIGH_CARD;
  end

endmodule

// File: rtl/poker_round_ctrl.sv
// Showdown round sequencer: loads all hands from a card stream, then scores one player per cycle.
module poker_round_ctrl
  import poker_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 4
) (
  input logic               clk,
  input logic               rst_n,
  poker_round_ctrl_if.slave bus
);

  localparam int unsigned PW = $clog2(NUM_PLAYERS);

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] ld_player;
  logic [2:0]    ld_slot;
  logic [PW-1:0] ptr;
  logic [3:0]    cur_type;
  logic [3:0]    best_type;
  logic [PW-1:0] winner;
  logic          tie;
  logic          card_ready;
  logic          busy;
  logic          res_valid;
  logic          accept;
  logic          last_card;
  logic          last_eval;

  logic [HAND_SIZE-1:0][CARD_W-1:0] hand [NUM_PLAYERS];

  assign accept    = (state == LOAD) && bus.card_valid;
  assign last_card = (ld_player == PW'(NUM_PLAYERS - 1)) && (ld_slot == 3'(HAND_SIZE - 1));
  assign last_eval = (ptr == PW'(NUM_PLAYERS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    card_ready = 1'b0;
    busy       = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = LOAD;
      LOAD: begin
        card_ready = 1'b1;
        busy       = 1'b1;
        if (accept && last_card) state_nxt = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        if (last_eval) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage is write-before-read every round, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) hand[ld_player][ld_slot] <= bus.card_data;
  end

  // The card counter is split into player/slot fields so storage indexing needs no multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_player <= '0;
      ld_slot   <= '0;
      ptr       <= '0;
      best_type <= '0;
      winner    <= '0;
      tie       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          ld_player <= '0;
          ld_slot   <= '0;
          best_type <= '0;
          winner    <= '0;
          tie       <= 1'b0;
        end
        LOAD: if (accept) begin
          if (ld_slot == 3'(HAND_SIZE - 1)) begin
            ld_slot   <= '0;
            ld_player <= ld_player + PW'(1);
          end else begin
            ld_slot <= ld_slot + 3'd1;
          end
          if (last_card) ptr <= '0;
        end
        EVAL: begin
          ptr <= ptr + PW'(1);
          if (ptr == '0) begin
            best_type <= cur_type;
            winner    <= '0;
            tie       <= 1'b0;
          end else if (cur_type > best_type) begin
            best_type <= cur_type;
            winner    <= ptr;
            tie       <= 1'b0;
          end else if (cur_type == best_type) begin
            tie <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  poker u_poker (
    .cards     (hand[ptr]),
    .hand_type (cur_type)
  );

  assign bus.card_ready = card_ready;
  assign bus.busy       = busy;
  assign bus.res_valid  = res_valid;
  assign bus.res_winner = winner;
  assign bus.res_type   = best_type;
  assign bus.res_tie    = tie;

endmodule

// File: tb/tb_poker_round_ctrl.sv
// Directed bench for poker_round_ctrl: table of showdown rounds plus reset, bubble and back-pressure sequences.
module tb_poker_round_ctrl;
  import poker_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned PW = $clog2(NP);

  typedef struct {
    logic [NP-1:0][29:0] hands;
    int                  winner;
    int                  htype;
    int                  tie;
  } round_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   acc_cnt;

  round_t rounds [7];

  poker_round_ctrl_if #(.NUM_PLAYERS(NP)) bus ();

  poker_round_ctrl #(.NUM_PLAYERS(NP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.card_valid && bus.card_ready) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Five cards; non-flush hands rotate suits 0,1,2,3,0.
  function automatic logic [29:0] h(input int r0, input int r1, input int r2,
                                    input int r3, input int r4, input bit fl);
    int r [5];
    int s;
    logic [29:0] res;
    r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3; r[4] = r4;
    res = '0;
    for (int i = 0; i < 5; i++) begin
      s = fl ? 1 : (i % 4);
      res[6*i +: 6] = {2'(s), 4'(r[i])};
    end
    return res;
  endfunction

  function automatic round_t mk_round(input logic [29:0] h0, input logic [29:0] h1,
                                      input logic [29:0] h2, input logic [29:0] h3,
                                      input int w, input int t, input int ti);
    round_t r;
    r.hands[0] = h0; r.hands[1] = h1; r.hands[2] = h2; r.hands[3] = h3;
    r.winner = w; r.htype = t; r.tie = ti;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_card(input logic [5:0] d, output bit ok);
    bus.card_valid = 1'b1;
    bus.card_data  = d;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (bus.card_ready) ok = 1'b1;
      step();
    end
    bus.card_valid = 1'b0;
  endtask

  task automatic run_round(input round_t r, input bit bubble, input bit start_in_eval, input int hold);
    int acc0;
    int n;
    bit ok;
    acc0 = acc_cnt;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("card_ready_after_start", bus.card_ready, 1);
    check("busy_in_load", bus.busy, 1);
    for (int p = 0; p < NP; p++) begin
      for (int c = 0; c < 5; c++) begin
        if (bubble) begin
          bus.card_valid = 1'b0;
          step();
        end
        send_card(r.hands[p][6*c +: 6], ok);
        if (!ok) check("card_accept_timeout", 0, 1);
      end
    end
    check("cards_accepted", acc_cnt - acc0, 20);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      if (start_in_eval && n == 0) bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      n++;
    end
    check("res_valid_latency", n, NP);
    check("res_winner", bus.res_winner, r.winner);
    check("res_type", bus.res_type, r.htype);
    check("res_tie", bus.res_tie, r.tie);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_stable", {bus.res_valid, bus.res_winner, bus.res_type, bus.res_tie},
            {1'b1, PW'(r.winner), 4'(r.htype), 1'(r.tie)});
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("res_valid_after_hs", bus.res_valid, 0);
    check("busy_after_hs", bus.busy, 0);
    check("card_ready_idle", bus.card_ready, 0);
    check("res_type_kept", bus.res_type, r.htype);
  endtask

  initial begin
    bit ok;
    int acc0;
    tests = 0;
    fails = 0;
    acc_cnt = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.card_valid = 1'b0;
    bus.card_data = '0;
    bus.res_ready = 1'b0;

    rounds[0] = mk_round(h(2,3,4,5,6,1), h(2,2,7,9,11,0), h(3,3,8,10,12,0), h(4,4,9,11,13,0), 0, 8, 0);
    rounds[1] = mk_round(h(2,5,7,9,11,0), h(3,6,8,10,12,0), h(9,9,9,9,2,0), h(4,6,8,10,13,0), 2, 7, 0);
    rounds[2] = mk_round(h(5,5,8,10,12,0), h(2,4,7,9,11,1), h(6,6,9,11,13,0), h(3,5,8,10,13,1), 1, 5, 1);
    rounds[3] = mk_round(h(4,4,7,7,12,0), h(8,8,8,3,5,0), h(14,2,3,4,5,0), h(10,10,10,6,6,0), 3, 6, 0);
    rounds[4] = mk_round(h(2,5,7,9,11,0), h(5,6,7,8,9,0), h(12,12,12,3,7,0), h(4,4,11,11,2,0), 1, 4, 0);
    rounds[5] = mk_round(h(6,6,2,9,12,0), h(7,7,3,10,13,0), h(2,5,8,11,13,1), h(3,5,7,9,11,0), 2, 5, 0);
    rounds[6] = mk_round(h(2,5,7,9,11,0), h(3,6,8,10,12,0), h(4,6,8,10,13,0), h(2,4,7,9,12,0), 0, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_card_ready", bus.card_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_winner", bus.res_winner, 0);
    check("rst_res_type", bus.res_type, 0);
    check("rst_res_tie", bus.res_tie, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Cards offered in IDLE must not be consumed.
    acc0 = acc_cnt;
    bus.card_valid = 1'b1;
    bus.card_data = 6'h12;
    repeat (3) step();
    bus.card_valid = 1'b0;
    check("idle_card_ignored", acc_cnt - acc0, 0);
    check("idle_card_ready", bus.card_ready, 0);

    for (int i = 0; i < 7; i++) run_round(rounds[i], 1'b0, 1'b0, 0);

    run_round(rounds[2], 1'b0, 1'b0, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      send_card(rounds[1].hands[c / 5][6*(c % 5) +: 6], ok);
      if (!ok) check("card_accept_timeout", 0, 1);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_card_ready", bus.card_ready, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_res_valid", bus.res_valid, 0);
    check("midrst_res_winner", bus.res_winner, 0);
    check("midrst_res_type", bus.res_type, 0);
    check("midrst_res_tie", bus.res_tie, 0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_round(rounds[1], 1'b0, 1'b0, 0);

    run_round(rounds[0], 1'b1, 1'b1, 0);
    run_round(rounds[2], 1'b0, 1'b0, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/poker_round_ctrl.md
# poker_round_ctrl

Sequencer for one showdown round: collects 5 cards for each of NUM_PLAYERS players over a serial card stream, then time-shares a single `poker` hand classifier across all stored hands, one player per cycle. It tracks the best hand type and reports the winner index, the winning type and a tie flag through a valid/ready result port. It sits between the dealer/stimulus front end and the scoring logic.

## Interface
- NUM_PLAYERS, 4: players per round, legal range 2..8.
- PW, $clog2(NUM_PLAYERS): width of the player index (derived, not overridden).
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a round; honoured only in IDLE.
- card_valid  in  1  card_data is valid this cycle.
- card_ready  out  1  high only in LOAD; a card is accepted on an edge where card_valid && card_ready.
- card_data  in  6  card: [5:4] suit, [3:0] rank.
- busy  out  1  high in LOAD, EVAL and DONE.
- res_valid  out  1  result available; held until accepted.
- res_ready  in  1  consumer accepts the result on an edge where res_valid && res_ready.
- res_winner  out  PW  index of the winning player.
- res_type  out  4  hand type of the winner.
- res_tie  out  1  another player matched res_type exactly.

## Operation
- Card order is fixed: player 0 cards 0..4, then player 1 cards 0..4, and so on. A card counter runs 0..5*NUM_PLAYERS-1 and writes into hand storage of NUM_PLAYERS x 5 x 6 bits.
- FSM:
  - IDLE: start -> LOAD, which clears the card counter, the best type, the winner and res_tie.
  - LOAD: on acceptance of the last card -> EVAL, with the player pointer at 0.
  - EVAL: each cycle, the hand of player p drives the classifier. The resulting type is compared against the best so far, and p increments.
    - Compare is unsigned; a larger type is stronger.
    - Player 0 always initialises best/winner, and res_tie goes to 0.
    - For later players, type > best replaces best/winner and clears res_tie. Type == best sets res_tie and keeps the lower index. Type < best changes nothing.
    - The cycle that evaluates player NUM_PLAYERS-1 -> DONE.
  - DONE: res_valid = 1. On handshake -> IDLE; the result outputs keep their values until the next start.
- start outside IDLE is ignored. card_valid outside LOAD is ignored and not consumed.
- Hand storage is not cleared by reset; every entry is rewritten before it is read.

## Timing
- Reset values: card_ready=0, busy=0, res_valid=0, res_winner=0, res_type=0, res_tie=0, FSM=IDLE.
- Reset asserted mid-round aborts immediately: outputs return to their reset values and the partial hand is discarded.
- start sampled at edge t -> card_ready=1 from cycle t+1.
- Card acceptance throughput is 1 card/cycle; card_valid may bubble at any point.
- Last card accepted at edge k: EVAL occupies cycles k+1 .. k+NUM_PLAYERS, and res_valid=1 from cycle k+NUM_PLAYERS+1.
- res_valid && res_ready at edge d: res_valid=0 and busy=0 from cycle d+1. The earliest next start is sampled at edge d+1.
- The classifier path is combinational within the EVAL cycle. The type is registered only in the best/winner registers; there is no extra pipeline stage.

## Structure
- The shared package poker_pkg holds:
  - card field widths (SUIT_W=2, RANK_W=4, CARD_W=6)
  - HAND_SIZE=5
  - type constants: HIGH_CARD=0, ONE_PAIR=1, TWO_PAIR=2, THREE_KIND=3, STRAIGHT=4, FLUSH=5, FULL_HOUSE=6, FOUR_KIND=7, STRAIGHT_FLUSH=8
  - the FSM state enum {IDLE, LOAD, EVAL, DONE}
- One sub-module instance: the existing `poker` classifier, with its inputs muxed from hand storage by the player pointer.

## Test plan
- Reset mid-LOAD after 7 cards -> all outputs at reset values. A new start then loads 20 cards and reports normally.
- NUM_PLAYERS=4:
  - P0 = ranks 2,3,4,5,6 all suit 1; P1..P3 = pairs -> res_winner=0, res_type=8, res_tie=0.
  - P2 = four 9s; P0, P1, P3 = high card -> res_winner=2, res_type=7, res_tie=0.
  - P1 and P3 both flushes; P0 and P2 one pair -> res_winner=1, res_type=5, res_tie=1.
- card_valid toggled 1,0,1,0 through LOAD, and start pulsed during EVAL:
  - exactly 20 cards accepted, start ignored
  - res_valid rises 4 cycles after the last-card edge
- res_ready held low for 10 cycles:
  - res_valid and the result outputs stay stable
  - on the handshake, IDLE is reached next cycle with busy=0.
